// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Optional feature macro: MDU_FLUSH_EN (see mdu_core).
package mdu_pkg;

  // Operation codes presented by EX alongside the start strobe.
  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  // Sequencer states: idle, or counting down an in-flight arithmetic op.
  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // Default latencies; both must stay within 1..15 to fit the counter.
  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;
  localparam int CNT_W               = 4;

  // True for the four ops that occupy the unit for several cycles.
  function automatic logic is_arith_op(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply / divide datapath. Produces the 64-bit
// {hi,lo} result for mult/multu/div/divu and flags division by zero.
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e      op,
  input  logic [31:0]  a,
  input  logic [31:0]  b,
  output logic [63:0]  result,
  output logic         div_by_zero
);

  logic signed [63:0] ext_a;
  logic signed [63:0] ext_b;
  logic        [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               signed_div;
  logic               a_neg;
  logic               b_neg;
  logic        [31:0] mag_a;
  logic        [31:0] mag_b;
  logic        [31:0] divisor;
  logic        [31:0] uq;
  logic        [31:0] ur;
  logic        [31:0] quot;
  logic        [31:0] rem;

  // Signed division is done on magnitudes and the signs are restored
  // afterwards, so 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave it unassigned (latch).
    result      = '0;
    ext_a       = {{32{a[31]}}, a};
    ext_b       = {{32{b[31]}}, b};
    prod_s      = 64'(ext_a * ext_b);
    prod_u      = 64'(a) * 64'(b);
    signed_div  = (op == MDU_DIV);
    a_neg       = signed_div && a[31];
    b_neg       = signed_div && b[31];
    mag_a       = a_neg ? -a : a;
    mag_b       = b_neg ? -b : b;
    div_by_zero = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == 32'd0);
    // Divide by one instead of zero; the sequencer discards the result anyway.
    divisor     = (b == 32'd0) ? 32'd1 : mag_b;
    uq          = mag_a / divisor;
    ur          = mag_a % divisor;
    quot        = (a_neg ^ b_neg) ? -uq : uq;
    rem         = a_neg ? -ur : ur;

    case (op)
      MDU_MULT:           result = prod_s;
      MDU_MULTU:          result = prod_u;
      MDU_DIV, MDU_DIVU:  result = {rem, quot};
      default:            result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_core.sv
// EX-stage multiply/divide unit with HI/LO registers. Arithmetic ops are
// computed on issue, held in temporaries and committed after a fixed
// latency while busy is high. Define MDU_FLUSH_EN to add a flush input
// that squashes an in-flight op or a coincident issue.
module mdu_core
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  mdu_op_e      mdu_op,
  input  logic [31:0]  src_a,
  input  logic [31:0]  src_b,
`ifdef MDU_FLUSH_EN
  input  logic         flush,
`endif
  output logic         busy,
  output logic         start_o,
  output logic [31:0]  hi,
  output logic [31:0]  lo,
  output logic [31:0]  rd_data
);

  mdu_state_e         state_q;
  mdu_state_e         state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        tmp_hi_q;
  logic [31:0]        tmp_lo_q;
  logic               tmp_dbz_q;
  logic [63:0]        arith_result;
  logic               arith_dbz;
  logic               is_arith;
  logic               is_div;
  logic               kill;
  logic               load;
  logic               done;
  logic               wr_hi_mt;
  logic               wr_lo_mt;

`ifdef MDU_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  assign is_arith = is_arith_op(mdu_op);
  assign is_div   = (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);
  // Hazard-unit strobe: independent of busy by design.
  assign start_o  = start && is_arith;

  mdu_arith u_arith (
    .op          (mdu_op),
    .a           (src_a),
    .b           (src_b),
    .result      (arith_result),
    .div_by_zero (arith_dbz)
  );

  // Next-state and control decode; issues are only accepted while idle.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    done     = 1'b0;
    wr_hi_mt = 1'b0;
    wr_lo_mt = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (start && !kill) begin
          if (is_arith) begin
            state_d = MDU_RUN;
            load    = 1'b1;
          end else if (mdu_op == MDU_MTHI) begin
            wr_hi_mt = 1'b1;
          end else if (mdu_op == MDU_MTLO) begin
            wr_lo_mt = 1'b1;
          end
        end
      end
      MDU_RUN: begin
        if (kill) begin
          state_d = MDU_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = MDU_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state is always written with non-blocking assignments so
    // every flop samples pre-edge values regardless of statement order.
    if (!reset_n) state_q <= MDU_IDLE;
    else          state_q <= state_d;
  end

  // Latency counter, result temporaries and busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      tmp_hi_q  <= '0;
      tmp_lo_q  <= '0;
      tmp_dbz_q <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_d == MDU_RUN);
      if (load) begin
        tmp_hi_q  <= arith_result[63:32];
        tmp_lo_q  <= arith_result[31:0];
        tmp_dbz_q <= arith_dbz;
        cnt_q     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (state_q == MDU_RUN) begin
        cnt_q <= (state_d == MDU_IDLE) ? '0 : cnt_q - CNT_W'(1);
      end
    end
  end

  // Architectural HI/LO: committed on completion or by mthi/mtlo.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (done && !tmp_dbz_q) begin
        hi <= tmp_hi_q;
        lo <= tmp_lo_q;
      end
      if (wr_hi_mt) hi <= src_a;
      if (wr_lo_mt) lo <= src_a;
    end
  end

  // mfhi/mflo read mux.
  always_comb begin
    rd_data = '0;
    case (mdu_op)
      MDU_MFHI: rd_data = hi;
      MDU_MFLO: rd_data = lo;
      default:  rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mdu_core.sv
// Self-checking bench for mdu_core: directed cases plus randomized ops
// compared against a plain-arithmetic HI/LO reference model.
module tb_mdu_core;
  import mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  mdu_op_e     mdu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
`ifdef MDU_FLUSH_EN
  logic        flush;
`endif
  logic        busy;
  logic        start_o;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference HI/LO.
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mdu_core dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .mdu_op  (mdu_op),
    .src_a   (src_a),
    .src_b   (src_b),
`ifdef MDU_FLUSH_EN
    .flush   (flush),
`endif
    .busy    (busy),
    .start_o (start_o),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Architectural effect of one op on HI/LO, from the ISA definition.
  task automatic model_apply(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MDU_MULT:  begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
      MDU_MULTU: begin p = ua * ub; hi_m = p[63:32]; lo_m = p[31:0]; end
      MDU_DIV:   if (b != 0) begin
                   q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0];
                 end
      MDU_DIVU:  if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      MDU_MTHI:  hi_m = a;
      MDU_MTLO:  lo_m = a;
      default:   ;
    endcase
  endtask

  function automatic int latency(input mdu_op_e op);
    if (op == MDU_MULT || op == MDU_MULTU) return MULT_N;
    if (op == MDU_DIV  || op == MDU_DIVU)  return DIV_N;
    return 0;
  endfunction

  // Issue one op for one cycle, then check busy over the whole latency
  // window and HI/LO in the first cycle after completion.
  task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [31:0] old_hi, old_lo;
    n = latency(op);
    old_hi = hi_m;
    old_lo = lo_m;
    @(negedge clk);
    start = 1'b1; mdu_op = op; src_a = a; src_b = b;
    #1 check("start_o", start_o, 32'(n != 0));
    model_apply(op, a, b);
    @(negedge clk);
    start = 1'b0; mdu_op = MDU_NONE;
    for (int i = 1; i <= n; i++) begin
      check($sformatf("busy_c%0d", i), busy, 1);
      if (i == 1) begin
        check("hi_hold", hi, old_hi);
        check("lo_hold", lo, old_lo);
      end
      @(negedge clk);
    end
    check("busy_done", busy, 0);
    check("hi", hi, hi_m);
    check("lo", lo, lo_m);
  endtask

  task automatic check_reads();
    @(negedge clk);
    mdu_op = MDU_MFHI; #1 check("rd_mfhi", rd_data, hi_m);
    mdu_op = MDU_MFLO; #1 check("rd_mflo", rd_data, lo_m);
    mdu_op = MDU_MTHI; #1 check("rd_other", rd_data, 32'd0);
    mdu_op = MDU_NONE;
  endtask

  initial begin
    mdu_op_e rops[6];
    mdu_op_e op;
    logic [31:0] a, b;
    rops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO};
    reset_n = 1'b0; start = 1'b0; mdu_op = MDU_NONE; src_a = '0; src_b = '0;
`ifdef MDU_FLUSH_EN
    flush = 1'b0;
`endif
    hi_m = '0; lo_m = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;

    // Directed cases with literal expectations as well as the model.
    run_op(MDU_MULT, 32'hFFFF_FFFF, 32'd2);
    check("mult_hi_lit", hi, 32'hFFFF_FFFF);
    check("mult_lo_lit", lo, 32'hFFFF_FFFE);
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
    check("multu_hi_lit", hi, 32'h0000_0001);
    check("multu_lo_lit", lo, 32'hFFFF_FFFE);
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_lo_lit", lo, 32'hFFFF_FFFD);
    check("div_hi_lit", hi, 32'hFFFF_FFFF);
    run_op(MDU_MTHI, 32'h1234_5678, 32'd0);
    run_op(MDU_MTLO, 32'h1234_5678, 32'd0);
    run_op(MDU_DIVU, 32'd7, 32'd0);
    check("dbz_hi_lit", hi, 32'h1234_5678);
    check("dbz_lo_lit", lo, 32'h1234_5678);
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("ovf_lo_lit", lo, 32'h8000_0000);
    check("ovf_hi_lit", hi, 32'h0000_0000);
    run_op(MDU_MTHI, 32'hDEAD_BEEF, 32'd0);
    check_reads();
    run_op(MDU_MFHI, 32'h5555_5555, 32'h1);
    run_op(MDU_NONE, 32'h5555_5555, 32'h1);

    // Issues while busy are ignored; start_o still reflects the strobe.
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_MULT; src_a = 32'd3; src_b = 32'd4;
    model_apply(MDU_MULT, 32'd3, 32'd4);
    @(negedge clk);
    mdu_op = MDU_DIV; src_a = 32'd100; src_b = 32'd5;
    #1 check("start_o_busy", start_o, 1);
    @(negedge clk);
    mdu_op = MDU_MTHI; src_a = 32'hAAAA_AAAA;
    @(negedge clk);
    start = 1'b0; mdu_op = MDU_NONE;
    @(negedge clk);
    check("ign_busy_c4", busy, 1);
    @(negedge clk);
    check("ign_busy_c5", busy, 1);
    @(negedge clk);
    check("ign_busy_end", busy, 0);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd12);

    // Randomized ops against the model.
    for (int k = 0; k < 40; k++) begin
      op = rops[$urandom_range(0, 5)];
      a  = $urandom();
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom());
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      run_op(op, a, b);
      if (k % 8 == 0) check_reads();
    end

`ifdef MDU_FLUSH_EN
    // Flush mid-run keeps the pre-op HI/LO.
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_MULT; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0; mdu_op = MDU_NONE;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_busy", busy, 0);
    check("fl_hi", hi, hi_m);
    check("fl_lo", lo, lo_m);
    // Flush coincident with mthi suppresses the write.
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_MTHI; src_a = ~hi_m; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; mdu_op = MDU_NONE; flush = 1'b0;
    check("fl_mthi", hi, hi_m);
    // Flush on the completion edge suppresses the commit.
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_MULTU; src_a = 32'd7; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0; mdu_op = MDU_NONE;
    repeat (MULT_N - 1) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_done_busy", busy, 0);
    check("fl_done_lo", lo, lo_m);
`endif

    // Async reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_MULT; src_a = 32'd123; src_b = 32'd456;
    @(negedge clk);
    start = 1'b0; mdu_op = MDU_NONE;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hi", hi, 0);
    check("mid_rst_lo", lo, 0);
    @(negedge clk);
    reset_n = 1'b1;
    hi_m = '0; lo_m = '0;
    repeat (MULT_N + 1) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_hi", hi, 0);
    check("post_rst_lo", lo, 0);
    run_op(MDU_MULTU, 32'd6, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net: the stimulus is finite, so this only trips on a bench bug.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mdu_core.md
Name: mdu_core

Overview:
- Multi-cycle multiply/divide unit in the EX stage, with HI/LO registers.
- Produces the `start`/`busy` pair that the hazard unit consumes to stall mfhi/mflo/mthi/mtlo and to squash new mult/div in ID.
- Executes mult, multu, div and divu with fixed latency.
- Serves mthi/mtlo writes and mfhi/mflo reads.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  issue strobe, valid for one cycle while the instruction is in EX.
- mdu_op  input  4  operation code (package enum), sampled with start; also drives the read mux.
- src_a  input  32  rs operand (forwarded value).
- src_b  input  32  rt operand (forwarded value).
- busy  output  1  registered; high while an arithmetic op is in flight.
- start_o  output  1  combinational: start && op is mult/multu/div/divu; fed to the hazard unit's Start input.
- hi  output  32  current HI register.
- lo  output  32  current LO register.
- rd_data  output  32  HI if mdu_op==MFHI, LO if mdu_op==MFLO, otherwise 0; combinational.

Behaviour:
- Reset (async, reset_n=0):
  - hi=0, lo=0, busy=0.
  - FSM=IDLE, counter=0, result temporaries=0.
  - Reset mid-operation abandons the op; HI/LO read 0 after release.
- FSM states:
  - IDLE → RUN: on start && arith op (MULT/MULTU/DIV/DIVU) at edge T.
    - Latch operands.
    - Compute 64-bit result into tmp_hi/tmp_lo.
    - Load counter with MULT_CYCLES or DIV_CYCLES.
    - Set busy=1.
  - RUN: counter decrements each edge.
    - When the counter reaches 1 at an edge: hi←tmp_hi, lo←tmp_lo, busy←0, FSM→IDLE.
    - busy is high for exactly N cycles, T+1..T+N.
    - New HI/LO are visible from cycle T+N+1, the same cycle busy first reads 0.
- Arithmetic:
  - mult: signed 32x32→64; {hi,lo}=product.
  - multu: unsigned 32x32→64; {hi,lo}=product.
  - div: signed; lo=quotient truncated toward zero; hi=remainder, taking the dividend's sign.
  - divu: unsigned quotient and remainder.
  - Divide by zero (src_b==0): still runs DIV_CYCLES with busy high; HI/LO are left unchanged at completion.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO:
  - On start with MTHI: hi←src_a at edge T; no busy.
  - On start with MTLO: lo←src_a at edge T; no busy.
  - MTHI/MTLO is ignored if busy=1; the hazard unit prevents this case.
- MFHI/MFLO: rd_data selects the current hi/lo combinationally; start is not required.
- start with an arith op while busy=1: ignored, and the in-flight op is unaffected. The hazard unit guarantees this does not occur.
- start with MDU_NONE or MFHI/MFLO: no state change.
- start_o never depends on busy.
- Stalls in the D stage never reach this block; EX receives a bubble (start=0).

Optional Feature:
- Macro: MDU_FLUSH_EN. When defined, adds input port `flush` (1 bit) for exception/eret squash.
- flush=1 at an edge while RUN: FSM→IDLE, busy←0, HI/LO keep their pre-op values, tmp discarded.
- flush=1 coincident with start: the start is suppressed, including MTHI/MTLO writes.
- flush=1 on the completion edge: the write is suppressed.
- When the macro is undefined: no `flush` port; an op always completes once started.

Decomposition:
- Package mdu_pkg holds:
  - the mdu_op enum: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8;
  - the FSM state enum IDLE/RUN;
  - default cycle-count constants.
- One sub-module, mdu_arith: purely combinational. Takes op/a/b and returns the 64-bit {hi,lo} result plus a div_by_zero flag.
- The FSM, counter and HI/LO registers stay in mdu_core.

Test Plan:
- Reset then MULT a=0xFFFFFFFF, b=2 at T.
  - busy=1 for T+1..T+5.
  - At T+6: hi=0xFFFFFFFF, lo=0xFFFFFFFE, busy=0.
- MULTU a=0xFFFFFFFF, b=2 → after 5 busy cycles: hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2.
  - busy for 10 cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7, b=0 with hi=lo=0x12345678 beforehand → busy for 10 cycles; hi/lo still 0x12345678.
- MTHI a=0xDEADBEEF → hi=0xDEADBEEF next cycle, busy stays 0. Then mdu_op=MFHI → rd_data=0xDEADBEEF.
- MULT started, reset_n pulsed low at T+3 → busy=0, hi=lo=0 immediately. With MDU_FLUSH_EN, flush at T+3 instead → busy=0 and hi/lo keep their prior values.
